// File: rtl/serial_subtractor_if.sv
// Start/busy/done bundle for serial_subtractor: the requester drives start and
// operands, the subtractor returns status and the registered result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  modport master (output start, a, b, input busy, done, diff, borrow, zero);
  modport slave  (input start, a, b, output busy, done, diff, borrow, zero);
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: BITS_PER_CYCLE full-subtractor slices per
// clock, borrow carried between cycles, result registered on entry to DONE.
module serial_subtractor #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus,
  output logic [1:0]          dbg_state_o
);
  // Handshake: start is sampled on a rising edge in IDLE or DONE and accepted
  // there; it is ignored in RUN. busy is high in RUN, done pulses one cycle in
  // DONE, and diff/borrow/zero hold from that cycle until the next DONE.
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              bin_q, bin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              zero_q, zero_d;

  logic [BITS_PER_CYCLE-1:0] slice_d;
  logic                      slice_bout;
  logic                      ripple;
  logic [WIDTH-1:0]          res_next;

  // Ripple the borrow through this cycle's slice group, LSB first.
  always_comb begin
    slice_d = '0;
    ripple  = bin_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      slice_d[i] = a_q[i] ^ b_q[i] ^ ripple;
      ripple     = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & ripple);
    end
    slice_bout = ripple;
    res_next   = res_q >> BITS_PER_CYCLE;
    res_next[WIDTH-1 -: BITS_PER_CYCLE] = slice_d;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = a_q >> BITS_PER_CYCLE;
        b_d   = b_q >> BITS_PER_CYCLE;
        res_d = res_next;
        bin_d = slice_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d  = S_DONE;
          diff_d   = res_next;
          borrow_d = slice_bout;
          zero_d   = (res_next == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.diff    = diff_q;
  assign bus.borrow  = borrow_q;
  assign bus.zero    = zero_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed checks on 8-bit instances (BPC 1 and 4)
// and a randomized regression over five 16-bit instances (BPC 1..16).
module tb_serial_subtractor;
  logic clk;
  logic rst;

  // Slots 0: W8/BPC1, 1: W8/BPC4, 2..6: W16/BPC 1,2,4,8,16.
  logic        st [7];
  logic [15:0] av [7];
  logic [15:0] bv [7];
  wire         bsy [7];
  wire         dn  [7];
  wire         brw [7];
  wire         zr  [7];
  wire  [15:0] df  [7];
  wire  [1:0]  dbg [7];

  int lat_exp [7];
  int wd      [7];
  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus_a ();
  serial_subtractor_if #(.WIDTH(8)) bus_b ();

  assign bus_a.start = st[0];
  assign bus_a.a     = av[0][7:0];
  assign bus_a.b     = bv[0][7:0];
  assign bsy[0] = bus_a.busy;
  assign dn[0]  = bus_a.done;
  assign brw[0] = bus_a.borrow;
  assign zr[0]  = bus_a.zero;
  assign df[0]  = {8'h00, bus_a.diff};

  assign bus_b.start = st[1];
  assign bus_b.a     = av[1][7:0];
  assign bus_b.b     = bv[1][7:0];
  assign bsy[1] = bus_b.busy;
  assign dn[1]  = bus_b.done;
  assign brw[1] = bus_b.borrow;
  assign zr[1]  = bus_b.zero;
  assign df[1]  = {8'h00, bus_b.diff};

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state_o(dbg[0])
  );
  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state_o(dbg[1])
  );

  for (genvar g = 0; g < 5; g++) begin : g16
    serial_subtractor_if #(.WIDTH(16)) bus ();
    assign bus.start  = st[g+2];
    assign bus.a      = av[g+2];
    assign bus.b      = bv[g+2];
    assign bsy[g+2]   = bus.busy;
    assign dn[g+2]    = bus.done;
    assign brw[g+2]   = bus.borrow;
    assign zr[g+2]    = bus.zero;
    assign df[g+2]    = bus.diff;
    serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(1 << g)) dut (
      .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg[g+2])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_diff(int k, logic [15:0] a, logic [15:0] b);
    logic [15:0] m;
    m = (wd[k] == 8) ? 16'h00FF : 16'hFFFF;
    return (a - b) & m;
  endfunction

  // Called right after the accept edge; returns in the done cycle.
  task automatic wait_result(int k, logic [15:0] a, logic [15:0] b);
    int cyc;
    cyc = 0;
    while (!dn[k] && cyc < 40) begin
      chk("busy_run", k, 32'(bsy[k]), 32'd1);
      tick();
      cyc++;
    end
    chk("latency", k, cyc, lat_exp[k]);
    chk("done_pulse", k, 32'(dn[k]), 32'd1);
    chk("busy_at_done", k, 32'(bsy[k]), 32'd0);
    chk("diff", k, 32'(df[k]), 32'(ref_diff(k, a, b)));
    chk("borrow", k, 32'(brw[k]), 32'(a < b));
    chk("zero", k, 32'(zr[k]), 32'(a == b));
  endtask

  task automatic op(int k, logic [15:0] a, logic [15:0] b);
    st[k] = 1'b1;
    av[k] = a;
    bv[k] = b;
    tick();
    st[k] = 1'b0;
    wait_result(k, a, b);
    tick();
    chk("done_drop", k, 32'(dn[k]), 32'd0);
    chk("busy_idle", k, 32'(bsy[k]), 32'd0);
    chk("diff_hold", k, 32'(df[k]), 32'(ref_diff(k, a, b)));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [15:0] tbl_a [3];
    logic [15:0] tbl_b [3];
    logic [4:0]  seen;
    int          cyc;

    checks   = 0;
    failures = 0;
    lat_exp  = '{8, 2, 16, 8, 4, 2, 1};
    wd       = '{8, 8, 16, 16, 16, 16, 16};
    tbl_a    = '{16'h0000, 16'hFFFF, 16'h0000};
    tbl_b    = '{16'h0000, 16'h0000, 16'hFFFF};
    for (int k = 0; k < 7; k++) begin
      st[k] = 1'b0;
      av[k] = '0;
      bv[k] = '0;
    end

    rst = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 7; k++) begin
      chk("rst_busy", k, 32'(bsy[k]), 32'd0);
      chk("rst_done", k, 32'(dn[k]), 32'd0);
      chk("rst_diff", k, 32'(df[k]), 32'd0);
      chk("rst_borrow", k, 32'(brw[k]), 32'd0);
      chk("rst_zero", k, 32'(zr[k]), 32'd0);
      chk("rst_state", k, 32'(dbg[k]), 32'd0);
    end
    rst = 1'b0;
    tick();

    op(0, 16'h005A, 16'h003C);
    op(0, 16'h0000, 16'h0001);
    op(0, 16'h00A5, 16'h00A5);
    op(1, 16'h0010, 16'h0001);
    op(1, 16'h0003, 16'h00F0);

    // start held through RUN with changing operands; re-accepted in DONE.
    st[0] = 1'b1;
    av[0] = 16'h0033;
    bv[0] = 16'h0010;
    tick();
    av[0] = 16'h0001;
    bv[0] = 16'h0002;
    wait_result(0, 16'h0033, 16'h0010);
    tick();
    st[0] = 1'b0;
    wait_result(0, 16'h0001, 16'h0002);
    tick();
    chk("b2b_done_drop", 0, 32'(dn[0]), 32'd0);

    // Leave zero=1 registered, then abort a run with reset mid-way.
    op(0, 16'h00A5, 16'h00A5);
    st[0] = 1'b1;
    av[0] = 16'h0011;
    bv[0] = 16'h0022;
    tick();
    st[0] = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 0, 32'(bsy[0]), 32'd0);
    chk("arst_done", 0, 32'(dn[0]), 32'd0);
    chk("arst_diff", 0, 32'(df[0]), 32'd0);
    chk("arst_borrow", 0, 32'(brw[0]), 32'd0);
    chk("arst_zero", 0, 32'(zr[0]), 32'd0);
    repeat (3) begin
      tick();
      chk("rst_hold_done", 0, 32'(dn[0]), 32'd0);
      chk("rst_hold_busy", 0, 32'(bsy[0]), 32'd0);
    end
    // start already high as reset releases: accepted on the first free edge.
    st[0] = 1'b1;
    av[0] = 16'h0080;
    bv[0] = 16'h0081;
    #2 rst = 1'b0;
    tick();
    st[0] = 1'b0;
    wait_result(0, 16'h0080, 16'h0081);
    tick();

    for (int n = 0; n < 1000; n++) begin
      if (n < 3) begin
        ra = tbl_a[n];
        rb = tbl_b[n];
      end else begin
        ra = 16'($urandom_range(0, 65535));
        rb = (n % 50 == 0) ? ra : 16'($urandom_range(0, 65535));
      end
      for (int k = 2; k < 7; k++) begin
        st[k] = 1'b1;
        av[k] = ra;
        bv[k] = rb;
      end
      tick();
      for (int k = 2; k < 7; k++) st[k] = 1'b0;
      cyc  = 0;
      seen = '0;
      while (cyc <= 20 && seen != 5'h1F) begin
        for (int k = 2; k < 7; k++) begin
          if (!seen[k-2]) begin
            if (dn[k]) begin
              seen[k-2] = 1'b1;
              chk("rnd_latency", k, cyc, lat_exp[k]);
              chk("rnd_diff", k, 32'(df[k]), 32'(ref_diff(k, ra, rb)));
              chk("rnd_borrow", k, 32'(brw[k]), 32'(ra < rb));
              chk("rnd_zero", k, 32'(zr[k]), 32'(ra == rb));
              chk("rnd_busy_at_done", k, 32'(bsy[k]), 32'd0);
            end else begin
              chk("rnd_busy", k, 32'(bsy[k]), 32'd1);
            end
          end
        end
        if (seen != 5'h1F) begin
          tick();
          cyc++;
        end
      end
      for (int k = 2; k < 7; k++) chk("rnd_seen", k, 32'(seen[k-2]), 32'd1);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
